// File: rtl/keypad_scanner_if.sv
// rtl/keypad_scanner_if.sv - keypad matrix drive/sense, key event and digit-register signals
// master is the scanner side, slave is the keypad/consumer side.
interface keypad_scanner_if;
    logic [3:0]  col_out;
    logic [3:0]  row_in;
    logic        key_valid;
    logic [3:0]  key_code;
    logic        key_held;
    logic [15:0] digits;

    modport master (
        output col_out,
        output key_valid,
        output key_code,
        output key_held,
        output digits,
        input  row_in
    );

    modport slave (
        input  col_out,
        input  key_valid,
        input  key_code,
        input  key_held,
        input  digits,
        output row_in
    );
endinterface

// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - 4x4 matrix keypad scanner with whole-matrix debounce and BCD entry register
// Columns are driven low one at a time; a matrix state is accepted after repeated identical scans.
module keypad_scanner #(
    parameter int SCAN_DIV       = 50000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic             clk,
    input  logic             rst,
    keypad_scanner_if.master kp
);
    localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int SW = (DEBOUNCE_SCANS > 1) ? $clog2(DEBOUNCE_SCANS) : 1;
    localparam logic [DW-1:0] DWELL_LAST  = DW'(SCAN_DIV - 1);
    localparam logic [SW-1:0] STABLE_LAST = SW'(DEBOUNCE_SCANS - 1);

    logic [3:0]    row_meta_q;
    logic [3:0]    row_sync_q;
    logic [DW-1:0] dwell_q, dwell_d;
    logic [1:0]    col_q, col_d;
    logic [3:0]    col_out_q, col_out_d;
    logic [15:0]   snap_q, snap_d;
    logic [15:0]   prev_q, prev_d;
    logic [15:0]   acc_q, acc_d;
    logic [SW-1:0] stable_q, stable_d;
    logic          armed_q, armed_d;
    logic          key_valid_q, key_valid_d;
    logic [3:0]    key_code_q, key_code_d;
    logic          key_held_q, key_held_d;
    logic [15:0]   digits_q, digits_d;

    logic          sample;
    logic          scan_done;
    logic          single;
    logic [3:0]    hit_idx;
    logic [3:0]    hit_code;

    // Snapshot bit index is 4*col+row; map it to the printed keypad legend.
    function automatic logic [3:0] decode_key(input logic [3:0] idx);
        logic [3:0] code;
        case (idx)
            4'd0:  code = 4'h1;
            4'd1:  code = 4'h4;
            4'd2:  code = 4'h7;
            4'd3:  code = 4'hE;
            4'd4:  code = 4'h2;
            4'd5:  code = 4'h5;
            4'd6:  code = 4'h8;
            4'd7:  code = 4'h0;
            4'd8:  code = 4'h3;
            4'd9:  code = 4'h6;
            4'd10: code = 4'h9;
            4'd11: code = 4'hF;
            4'd12: code = 4'hA;
            4'd13: code = 4'hB;
            4'd14: code = 4'hC;
            default: code = 4'hD;
        endcase
        return code;
    endfunction

    // Rows are asynchronous to clk; plain two-stage synchronizer, no reset needed.
    always_ff @(posedge clk) begin
        row_meta_q <= kp.row_in;
        row_sync_q <= row_meta_q;
    end

    always_comb begin
        sample    = (dwell_q == DWELL_LAST);
        scan_done = sample && (col_q == 2'd3);
        dwell_d   = dwell_q + 1'b1;
        col_d     = col_q;
        col_out_d = col_out_q;
        snap_d    = snap_q;
        if (sample) begin
            dwell_d   = '0;
            col_d     = col_q + 2'd1;
            col_out_d = ~(4'b0001 << col_d);
            snap_d[{col_q, 2'b00} +: 4] = ~row_sync_q;
        end
    end

    // snap_d already holds the column-3 bits on the scan_done cycle, so it is the completed scan.
    always_comb begin
        prev_d   = prev_q;
        stable_d = stable_q;
        acc_d    = acc_q;
        if (scan_done) begin
            if (snap_d == prev_q) begin
                stable_d = (stable_q == STABLE_LAST) ? stable_q : stable_q + 1'b1;
            end else begin
                stable_d = '0;
            end
            if (stable_d == STABLE_LAST) begin
                acc_d = snap_d;
            end
            prev_d = snap_d;
        end
    end

    always_comb begin
        hit_idx = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (acc_q[i]) begin
                hit_idx = 4'(i);
            end
        end
        hit_code = decode_key(hit_idx);
        single   = ($countones(acc_q) == 1);
    end

    // armed only re-arms on a full release, which suppresses rollover and multi-key events.
    always_comb begin
        key_valid_d = 1'b0;
        key_code_d  = key_code_q;
        key_held_d  = single;
        armed_d     = armed_q;
        digits_d    = digits_q;
        if (acc_q == 16'h0000) begin
            armed_d = 1'b1;
        end else if (armed_q && single) begin
            key_valid_d = 1'b1;
            key_code_d  = hit_code;
            armed_d     = 1'b0;
            if (hit_code <= 4'd9) begin
                digits_d = {digits_q[11:0], hit_code};
            end else if (hit_code == 4'hE) begin
                digits_d = 16'h0000;
            end else if (hit_code == 4'hF) begin
                digits_d = {4'h0, digits_q[15:4]};
            end
        end else begin
            armed_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dwell_q     <= '0;
            col_q       <= 2'd0;
            col_out_q   <= 4'b1110;
            snap_q      <= 16'h0000;
            prev_q      <= 16'h0000;
            acc_q       <= 16'h0000;
            stable_q    <= '0;
            armed_q     <= 1'b1;
            key_valid_q <= 1'b0;
            key_code_q  <= 4'h0;
            key_held_q  <= 1'b0;
            digits_q    <= 16'h0000;
        end else begin
            dwell_q     <= dwell_d;
            col_q       <= col_d;
            col_out_q   <= col_out_d;
            snap_q      <= snap_d;
            prev_q      <= prev_d;
            acc_q       <= acc_d;
            stable_q    <= stable_d;
            armed_q     <= armed_d;
            key_valid_q <= key_valid_d;
            key_code_q  <= key_code_d;
            key_held_q  <= key_held_d;
            digits_q    <= digits_d;
        end
    end

    assign kp.col_out   = col_out_q;
    assign kp.key_valid = key_valid_q;
    assign kp.key_code  = key_code_q;
    assign kp.key_held  = key_held_q;
    assign kp.digits    = digits_q;
endmodule

// File: tb/tb_keypad_scanner.sv
// tb/tb_keypad_scanner.sv - keypad_scanner bench: directed plan plus random key patterns vs a scan-level model
// The model sees one key pattern per scan and applies the debounce/event/digit rules arithmetically.
module tb_keypad_scanner;
    localparam int SD   = 4;
    localparam int DEB  = 2;
    localparam int SCAN = 4 * SD;

    typedef struct {
        logic [3:0]  code;
        logic [15:0] digits;
        int          cyc;
    } ev_t;

    logic        clk  = 1'b0;
    logic        rst  = 1'b1;
    logic [15:0] keys = 16'h0000;
    logic [15:0] cur  = 16'h0000;
    logic [3:0]  row_drv;
    int          cyc      = 0;
    int          n_vec    = 0;
    int          n_err    = 0;
    int          n_pulses = 0;
    int          m_events = 0;
    int          base_pulses;
    ev_t         exp_q[$];
    ev_t         ev_mon;
    string       km = "123A456B789CE0FD";
    logic [15:0] m_prev;
    logic [15:0] m_acc;
    logic [3:0]  m_code;
    int          m_run;
    int          m_digits;
    logic [15:0] seq_digits [5];

    keypad_scanner_if kif();

    keypad_scanner #(
        .SCAN_DIV       (SD),
        .DEBOUNCE_SCANS (DEB)
    ) dut (
        .clk (clk),
        .rst (rst),
        .kp  (kif)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Passive keypad: a pressed key shorts its row to the currently driven (low) column.
    always_comb begin
        row_drv = 4'hF;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                if (kif.col_out[c] === 1'b0 && keys[4*c+r]) row_drv[r] = 1'b0;
            end
        end
    end
    assign kif.row_in = row_drv;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] code_of(input int idx);
        byte ch;
        ch = km[(idx % 4) * 4 + idx / 4];
        return (ch >= 8'h41) ? 4'(ch - 8'h37) : 4'(ch - 8'h30);
    endfunction

    function automatic int bit_of(input logic [3:0] code);
        for (int i = 0; i < 16; i++) begin
            if (code_of(i) == code) return i;
        end
        return 0;
    endfunction

    task automatic model_reset();
        m_prev   = 16'h0000;
        m_run    = 1;
        m_acc    = 16'h0000;
        m_digits = 0;
        m_code   = 4'h0;
        exp_q.delete();
    endtask

    // Pattern accepted once seen in DEB consecutive scans (reset counts as one all-released scan);
    // an event fires only when an accepted single key follows an accepted all-released state.
    task automatic model_scan(input logic [15:0] p);
        int k;
        if (p == m_prev) m_run++;
        else m_run = 1;
        m_prev = p;
        if (m_run >= DEB && p != m_acc) begin
            if ($countones(p) == 1 && m_acc == 16'h0000) begin
                k = 0;
                for (int i = 0; i < 16; i++) if (p[i]) k = i;
                m_code = code_of(k);
                if (m_code <= 4'd9) m_digits = (m_digits * 16 + int'(m_code)) % 65536;
                else if (m_code == 4'hE) m_digits = 0;
                else if (m_code == 4'hF) m_digits = m_digits / 16;
                exp_q.push_back('{m_code, 16'(m_digits), cyc + 1});
                m_events++;
            end
            m_acc = p;
        end
    endtask

    // One full scan; bb >= 0 makes that key bounce every 10 cycles, boff being the bounce phase.
    task automatic run_scan(input logic [15:0] pat, input int bb, input int boff);
        logic [15:0] seen;
        logic [3:0]  exp_col;
        keys = pat;
        seen = pat;
        if (bb >= 0) begin
            keys[bb] = (((boff / 10) % 2) == 0);
            seen[bb] = ((((boff + SD * (bb / 4) + 1) / 10) % 2) == 0);
        end
        for (int j = 1; j <= SCAN; j++) begin
            @(posedge clk);
            #1;
            exp_col = ~(4'b0001 << ((j / SD) % 4));
            check_eq("col_out", kif.col_out, exp_col);
            if (bb >= 0) keys[bb] = ((((boff + j) / 10) % 2) == 0);
        end
        model_scan(seen);
    endtask

    task automatic checkpoint(input string tag);
        repeat (DEB + 1) run_scan(cur, -1, 0);
        check_eq({tag, ":missing_pulse"}, exp_q.size(), 0);
        check_eq({tag, ":key_held"}, kif.key_held, ($countones(m_acc) == 1));
        check_eq({tag, ":digits"}, kif.digits, m_digits[15:0]);
        check_eq({tag, ":key_code"}, kif.key_code, m_code);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        check_eq("rst:col_out", kif.col_out, 4'hE);
        check_eq("rst:key_valid", kif.key_valid, 1'b0);
        check_eq("rst:key_code", kif.key_code, 4'h0);
        check_eq("rst:key_held", kif.key_held, 1'b0);
        check_eq("rst:digits", kif.digits, 16'h0000);
    endtask

    task automatic press_release(input logic [3:0] code, input int hold);
        cur = 16'(1) << bit_of(code);
        repeat (hold) run_scan(cur, -1, 0);
        cur = 16'h0000;
        checkpoint("release");
    endtask

    initial forever begin
        @(negedge clk);
        if (kif.key_valid === 1'b1) begin
            n_pulses++;
            check_eq("pulse_expected", (exp_q.size() != 0), 1'b1);
            if (exp_q.size() != 0) begin
                ev_mon = exp_q.pop_front();
                check_eq("pulse_code", kif.key_code, ev_mon.code);
                check_eq("pulse_digits", kif.digits, ev_mon.digits);
                check_eq("pulse_cycle", cyc, ev_mon.cyc);
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached, expected end of test");
        $fatal(1);
    end

    initial begin
        seq_digits[0] = 16'h0001;
        seq_digits[1] = 16'h0012;
        seq_digits[2] = 16'h0123;
        seq_digits[3] = 16'h1234;
        seq_digits[4] = 16'h2345;
        repeat (4) @(posedge clk);
        #1;
        do_reset();

        cur = 16'h0000;
        repeat (2) run_scan(cur, -1, 0);
        checkpoint("idle");
        check_eq("idle:pulses", n_pulses, 0);

        cur = 16'(1) << bit_of(4'h5);
        repeat (5) run_scan(cur, -1, 0);
        checkpoint("key5");
        check_eq("key5:pulses", n_pulses, 1);
        check_eq("key5:code", kif.key_code, 4'h5);
        check_eq("key5:digits", kif.digits, 16'h0005);
        check_eq("key5:held", kif.key_held, 1'b1);
        cur = 16'h0000;
        checkpoint("key5_rel");
        check_eq("key5_rel:held", kif.key_held, 1'b0);
        check_eq("key5_rel:pulses", n_pulses, 1);

        do_reset();
        for (int i = 0; i < 5; i++) begin
            press_release(4'(i + 1), 3);
            check_eq("seq_digits", kif.digits, seq_digits[i]);
        end
        press_release(4'hF, 3);
        check_eq("hash_digits", kif.digits, 16'h0234);
        press_release(4'hE, 3);
        check_eq("star_digits", kif.digits, 16'h0000);
        press_release(4'hA, 3);
        check_eq("keyA_code", kif.key_code, 4'hA);
        check_eq("keyA_digits", kif.digits, 16'h0000);

        base_pulses = n_pulses;
        for (int s = 0; s < 3; s++) run_scan(16'h0000, bit_of(4'h7), s * SCAN);
        cur = 16'(1) << bit_of(4'h7);
        checkpoint("bounce7");
        check_eq("bounce7:pulses", n_pulses - base_pulses, 1);
        check_eq("bounce7:code", kif.key_code, 4'h7);
        cur = 16'h0000;
        checkpoint("bounce7_rel");

        base_pulses = n_pulses;
        cur = (16'(1) << bit_of(4'h1)) | (16'(1) << bit_of(4'h2));
        checkpoint("multi");
        check_eq("multi:held", kif.key_held, 1'b0);
        cur = 16'(1) << bit_of(4'h1);
        checkpoint("rollback");
        check_eq("rollback:pulses", n_pulses - base_pulses, 0);
        cur = 16'h0000;
        checkpoint("multi_rel");
        cur = 16'(1) << bit_of(4'h3);
        checkpoint("key3");
        check_eq("key3:pulses", n_pulses - base_pulses, 1);
        check_eq("key3:code", kif.key_code, 4'h3);
        cur = 16'h0000;
        checkpoint("key3_rel");

        cur = 16'(1) << bit_of(4'h9);
        checkpoint("key9");
        do_reset();
        base_pulses = n_pulses;
        checkpoint("key9_after_rst");
        check_eq("key9_after_rst:pulses", n_pulses - base_pulses, 1);
        check_eq("key9_after_rst:code", kif.key_code, 4'h9);
        check_eq("key9_after_rst:digits", kif.digits, 16'h0009);
        cur = 16'h0000;
        checkpoint("key9_rel");

        for (int it = 0; it < 60; it++) begin
            int kind;
            int a;
            int b;
            int hold;
            kind = int'($urandom_range(0, 3));
            a    = int'($urandom_range(0, 15));
            b    = (a + 1 + int'($urandom_range(0, 14))) % 16;
            hold = int'($urandom_range(1, 3));
            case (kind)
                0:       cur = 16'h0000;
                1, 2:    cur = 16'(1) << a;
                default: cur = (16'(1) << a) | (16'(1) << b);
            endcase
            repeat (hold) run_scan(cur, -1, 0);
            if (it % 15 == 14) checkpoint("rand");
        end
        cur = 16'h0000;
        checkpoint("rand_end");
        check_eq("pulse_total", n_pulses, m_events);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Scans a 4x4 matrix keypad and debounces the whole key matrix.
- Emits one-cycle key events with a 4-bit key code.
- Maintains a 4-digit BCD entry register whose 16-bit output feeds the multiplexed 7-segment display controller.
- It is the input-side scanner, the counterpart of the display's column/enable scanning on the output side.

Parameters:
- SCAN_DIV, 50000: clock cycles each column is driven (dwell). Must be >= 4.
- DEBOUNCE_SCANS, 4: consecutive identical full scans required before the matrix state is accepted. Must be >= 1.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- col_out  output  4  column drive, active-low one-hot
- row_in  input  4  row sense, active-low (external pull-ups), asynchronous
- key_valid  output  1  one-cycle pulse per accepted key press
- key_code  output  4  code of the last accepted key, held until the next event
- key_held  output  1  accepted state contains exactly one pressed key
- digits  output  16  four BCD digits: [15:12] thousands … [3:0] units

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high. All outputs are registered.
- Reset values:
  - col_out=4'b1110; dwell counter=0; column index=0
  - snapshot, previous snapshot, accepted state = 16'h0000; stable counter=0; armed=1
  - key_valid=0, key_code=0, key_held=0, digits=16'h0000
- Row synchronizer: row_in passes through 2 flip-flops; no reset dependence.
- Scan:
  - Dwell counter counts 0..SCAN_DIV-1 per column.
  - At count SCAN_DIV-1: the inverted synchronized rows are stored into snapshot bits [4*col+3 : 4*col], with bit r = row r. Column index then advances 0→1→2→3→0.
  - col_out = ~(1<<col) and changes on the same edge as the index.
  - Full scan = 4*SCAN_DIV cycles.
- Debounce, at end of scan (col 3 sample edge):
  - If the completed snapshot equals the previous snapshot, stable counter increments, saturating at DEBOUNCE_SCANS-1. Otherwise it clears to 0.
  - When the counter (after update) equals DEBOUNCE_SCANS-1, accepted <= snapshot.
  - Previous snapshot <= completed snapshot.
- Key map (row,col)→code:
  - row0: 1,2,3,A
  - row1: 4,5,6,B
  - row2: 7,8,9,C
  - row3: *(E),0,#(F),D
- Event logic, evaluated on the cycle after accepted updates:
  - single = exactly one accepted bit set.
  - If armed and single: key_valid=1 for exactly one cycle; key_code=decoded code; armed=0.
  - If accepted==0: armed=1.
  - If accepted is nonzero and not single: armed=0, no event.
  - key_held=single, updated on the same cycle.
- Consequences:
  - Rollover (key X → key Y without all-release) produces no second event.
  - Multi-key → single produces no event.
  - Release produces no event.
- Digit register, updated on the same edge key_valid rises:
  - Code 0-9: digits <= {digits[11:0], code}; the thousands digit is dropped.
  - E (*): digits <= 0.
  - F (#): digits <= {4'h0, digits[15:4]}.
  - A-D: digits unchanged.
- Latency: a press stable from the start of a scan produces key_valid DEBOUNCE_SCANS*4*SCAN_DIV + 1 cycles after that scan begins.
- rst mid-operation: everything returns to reset values with armed=1. A key still held after reset is reported once after debounce.
- SCAN_DIV>=4 guarantees the synchronizer has settled for the driven column before sampling.

Test Plan (SCAN_DIV=4, DEBOUNCE_SCANS=2, scan = 16 cycles):
- Reset, no keys -> col_out=1110 then 1101, 1011, 0111 every 4 cycles, repeating; key_valid never pulses; digits=0x0000; key_held=0.
- Model pulls row1 low while col1 is driven, held 5 scans -> exactly one key_valid pulse with key_code=5, digits=0x0005, key_held=1. Release -> key_held=0 after 2 scans, no pulse.
- Press/release 1,2,3,4,5 -> digits 0x0001, 0x0012, 0x0123, 0x1234, 0x2345. Then # -> 0x0234, then * -> 0x0000. Press A -> key_code=A, digits stay 0x0000.
- Key 7 bouncing every 10 cycles for 3 scans, then stable -> exactly one pulse with key_code=7.
- Keys 1 and 2 pressed together -> no pulse, key_held=0. Release 2 while holding 1 -> still no pulse. Release all, press 3 -> one pulse with code 3.
- Hold 9 until its pulse, assert rst for 1 cycle while still holding -> all outputs zero, digits=0. One new pulse with code 9 after 2 scans.
